// File: rtl/output_display_if.sv
// Controller-facing bundle of the output display: load strobe, W-bus value,
// registered output value, conversion status and multiplexed 7-segment drive.
interface output_display_if;
  logic       Lo;
  logic [7:0] wbus;
  logic [7:0] out_reg;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (output Lo, wbus, input out_reg, busy, seg, an);
  modport slave  (input Lo, wbus, output out_reg, busy, seg, an);
endinterface

// File: rtl/output_display.sv
// Output register with serial double-dabble binary-to-BCD conversion and a
// multiplexed, leading-zero-blanked 3-digit active-low 7-segment display.
module output_display #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input logic             clk,
  input logic             reset,
  output_display_if.slave bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state_q, state_d;
  logic [7:0]    out_q, out_d;
  logic [7:0]    bin_q, bin_d;
  logic [9:0]    bcd_q, bcd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    hund_q, hund_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic [3:0]    tens_adj, ones_adj;
  logic [17:0]   shifted;
  logic          wrap;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  // Hundreds never exceeds 1 before a shift, so its upper bit can be dropped.
  always_comb begin
    ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    shifted  = {bcd_q[8], tens_adj, ones_adj, bin_q, 1'b0};
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (bus.Lo) begin
      out_d   = bus.wbus;
      bin_d   = bus.wbus;
      bcd_d   = '0;
      cnt_d   = '0;
      state_d = CONV;
    end else if (state_q == CONV) begin
      bcd_d = shifted[17:8];
      bin_d = shifted[7:0];
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        state_d = IDLE;
        hund_d  = shifted[17:16];
        tens_d  = shifted[15:12];
        ones_d  = shifted[11:8];
      end
    end
  end

  // seg/an are computed from next-state index and digits so the registered
  // drive matches the current slot and any commit on the same edge.
  always_comb begin
    wrap  = (pre_q == PW'(SCAN_DIV - 1));
    pre_d = wrap ? '0 : pre_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    an_d  = '1;
    seg_d = '1;
    case (idx_d)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = pat(ones_d);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = (hund_d == 2'd0 && tens_d == 4'd0) ? 7'b1111111 : pat(tens_d);
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = (hund_d == 2'd0) ? 7'b1111111 : pat({2'b00, hund_d});
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = 7'b1111111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.out_reg = out_q;
  assign bus.busy    = (state_q == CONV);
  assign bus.seg     = seg_q;
  assign bus.an      = an_q;

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 Parameter: SCAN_DIV, default 1024, clk cycles per display digit slot; legal values >= 2.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately, independent of clk.
REQ-004 Lo  input  1  load-output strobe from the controller, active-high, sampled on the rising clk edge.
REQ-005 wbus  input  8  W-bus value, unsigned; captured when Lo is sampled high.
REQ-006 out_reg  output  8  registered output-register contents.
REQ-007 busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-008 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 an  output  4  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=unused.

Function
REQ-010 Lo sampled high at edge E0 SHALL load out_reg<=wbus, load the conversion shift register with wbus, clear the iteration count, set busy=1 and enter state CONV.
REQ-011 FSM states SHALL be IDLE and CONV only: IDLE->CONV on Lo; CONV->IDLE after the 8th iteration; CONV->CONV on Lo (restart).
REQ-012 In CONV, each of edges E1..E8 SHALL perform one double-dabble iteration: add 3 to every 4-bit BCD nibble >= 5, then shift {BCD,binary} left by 1.
REQ-013 The BCD scratch SHALL be 10 bits (hundreds 2 bits, tens 4, ones 4); hundreds SHALL never exceed 2.
REQ-014 At E8 the result SHALL commit to the display digit registers, busy SHALL fall and the FSM SHALL return to IDLE: 8 cycles of busy, new digits visible from E8.
REQ-015 Display digit registers SHALL hold the previous result during CONV; no partial result is ever displayed.
REQ-016 Lo sampled high during CONV SHALL abort the current conversion and restart per REQ-010 with the new wbus; the previous display stays until the new commit.
REQ-017 Lo held high for N cycles SHALL restart on every edge; the commit occurs 8 edges after the last high sample.
REQ-018 Scan: a prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-019 Exactly one an bit SHALL be low at any time, matching the digit index; seg SHALL present that digit's pattern in the same cycle.
REQ-020 Digit index 3 SHALL drive seg=7'b1111111 (blank).
REQ-021 Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens are both 0; ones never blank.
REQ-022 Patterns for 0-9 (active-low {g..a}): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-023 seg and an SHALL be registered outputs, free of glitches between slots.
REQ-024 Conversion and scan logic SHALL be independent; Lo SHALL never disturb the prescaler or digit index.

Reset
REQ-025 While reset=0: out_reg=0, busy=0, FSM=IDLE, iteration count=0, display digits=0/0/0, prescaler=0, digit index=0, an=4'b1110, seg=7'b1000000.
REQ-026 Reset asserted mid-conversion SHALL discard the conversion entirely; no commit follows release.
REQ-027 After release, the first Lo SHALL behave as REQ-010 with no extra latency.

Verification
REQ-028 wbus=8'd255, Lo for 1 cycle -> out_reg=255 next edge, busy high 8 cycles, digits 2/5/5 from E8.
REQ-029 wbus=8'd7 -> hundreds and tens slots seg=1111111, ones slot seg=1111000; wbus=8'd0 -> only ones shows 1000000.
REQ-030 Load 8'd100, then at E3 load 8'd42 -> display never shows 100, shows 4/2 at 8 edges after the second load, busy continuous.
REQ-031 Load 8'd200, assert reset at E4, release -> out_reg=0, busy=0, display "0", no later commit.
REQ-032 SCAN_DIV=4 -> an sequence 1110,1101,1011,0111 repeating, 4 cycles each, one-low invariant holds every cycle.
REQ-033 Random wbus sweep 0..255 -> committed BCD equals decimal value of out_reg in every case.
